// File: rtl/store_pkg.sv
// Shared types and constants for the 32-bit to 16-bit store narrower.
package store_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BEAT_W = 16;
  localparam int unsigned BE_W   = 2;

  typedef enum logic [1:0] {
    ST_SB      = 2'b00,
    ST_SH      = 2'b01,
    ST_SW      = 2'b10,
    ST_ILLEGAL = 2'b11
  } store_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10,
    ERR   = 2'b11
  } state_e;

  localparam logic [BE_W-1:0] BE_LO  = 2'b01;
  localparam logic [BE_W-1:0] BE_HI  = 2'b10;
  localparam logic [BE_W-1:0] BE_ALL = 2'b11;

  // True when the request must be rejected (illegal type or misaligned address).
  function automatic logic is_bad(store_type_e t, logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (t)
      ST_SW:      bad = (addr_lo != 2'b00);
      ST_SH:      bad = addr_lo[0];
      ST_SB:      bad = 1'b0;
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_lane_mux.sv
// Maps a store (addr/data/type) and beat index onto one 16-bit bus beat.
module store_lane_mux
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  store_type_e       stype,
  input  logic              beat,
  output logic [ADDR_W-1:0] beat_addr_c,
  output logic [BEAT_W-1:0] beat_wdata_c,
  output logic [BE_W-1:0]   beat_be_c
);

  always_comb begin
    beat_addr_c  = {addr[ADDR_W-1:1], 1'b0};
    beat_wdata_c = wdata[BEAT_W-1:0];
    beat_be_c    = BE_ALL;
    case (stype)
      // Word base is word-aligned, so the second beat only sets bit 1.
      ST_SW: begin
        beat_addr_c  = {addr[ADDR_W-1:2], beat, 1'b0};
        beat_wdata_c = beat ? wdata[DATA_W-1:BEAT_W] : wdata[BEAT_W-1:0];
      end
      ST_SB: begin
        beat_wdata_c = {wdata[7:0], wdata[7:0]};
        beat_be_c    = addr[0] ? BE_HI : BE_LO;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_narrower.sv
// Serializes 32-bit sw/sh/sb stores onto a 16-bit write bus; rejects misaligned/illegal ones.
module store_narrower
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_type,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [BEAT_W-1:0] bus_wdata,
  output logic [BE_W-1:0]   bus_be,
  output logic              done,
  output logic              err
);

  state_e             state, state_n;
  logic [ADDR_W-1:0]  cap_addr;
  logic [DATA_W-1:0]  cap_wdata;
  store_type_e        cap_type;

  logic               accept_c;
  logic               load_beat_c;
  logic               beat_sel_c;
  logic               done_n_c;
  store_type_e        req_type_c;

  logic [ADDR_W-1:0]  mux_addr;
  logic [DATA_W-1:0]  mux_wdata;
  store_type_e        mux_type;
  logic [ADDR_W-1:0]  beat_addr_c;
  logic [BEAT_W-1:0]  beat_wdata_c;
  logic [BE_W-1:0]    beat_be_c;

  assign req_type_c = store_type_e'(req_type);
  assign accept_c   = req_valid && req_ready;

  // First beat is built from the live request so it can be registered at accept.
  assign mux_addr  = (state == IDLE) ? req_addr   : cap_addr;
  assign mux_wdata = (state == IDLE) ? req_wdata  : cap_wdata;
  assign mux_type  = (state == IDLE) ? req_type_c : cap_type;

  store_lane_mux #(.ADDR_W(ADDR_W)) u_lane_mux (
    .addr         (mux_addr),
    .wdata        (mux_wdata),
    .stype        (mux_type),
    .beat         (beat_sel_c),
    .beat_addr_c  (beat_addr_c),
    .beat_wdata_c (beat_wdata_c),
    .beat_be_c    (beat_be_c)
  );

  // Next-state and beat-load decisions.
  always_comb begin
    state_n     = state;
    load_beat_c = 1'b0;
    beat_sel_c  = 1'b0;
    done_n_c    = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (is_bad(req_type_c, req_addr[1:0])) begin
            state_n = ERR;
          end else begin
            state_n     = BEAT0;
            load_beat_c = 1'b1;
          end
        end
      end
      BEAT0: begin
        if (bus_ready) begin
          if (cap_type == ST_SW) begin
            state_n     = BEAT1;
            load_beat_c = 1'b1;
            beat_sel_c  = 1'b1;
          end else begin
            state_n  = IDLE;
            done_n_c = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (bus_ready) begin
          state_n  = IDLE;
          done_n_c = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, capture and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_type  <= ST_SB;
      req_ready <= 1'b0;
      bus_valid <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      req_ready <= (state_n == IDLE);
      bus_valid <= (state_n == BEAT0) || (state_n == BEAT1);
      done      <= done_n_c;
      err       <= (state_n == ERR);
      if (accept_c) begin
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_type  <= req_type_c;
      end
      if (load_beat_c) begin
        bus_addr  <= beat_addr_c;
        bus_wdata <= beat_wdata_c;
        bus_be    <= beat_be_c;
      end
    end
  end

endmodule

// File: tb/tb_store_narrower.sv
// Directed self-checking bench for store_narrower.
module tb_store_narrower;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_type;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic [15:0] bus_wdata;
  logic [1:0]  bus_be;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  store_narrower #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_type  (req_type),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] a, input logic [15:0] d,
                          input logic [1:0] be);
    check({tag, ".valid"}, 64'(bus_valid), 64'd1);
    check({tag, ".addr"},  64'(bus_addr),  64'(a));
    check({tag, ".data"},  64'(bus_wdata), 64'(d));
    check({tag, ".be"},    64'(bus_be),    64'(be));
    check({tag, ".rdy"},   64'(req_ready), 64'd0);
    check({tag, ".done"},  64'(done),      64'd0);
  endtask

  task automatic chk_done(input string tag);
    check({tag, ".done"},  64'(done),      64'd1);
    check({tag, ".err"},   64'(err),       64'd0);
    check({tag, ".valid"}, 64'(bus_valid), 64'd0);
    check({tag, ".rdy"},   64'(req_ready), 64'd1);
  endtask

  // Present a request for exactly one cycle (caller is in an idle cycle).
  task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_type  = t;
    req_addr  = a;
    req_wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic reject(input string tag, input logic [1:0] t, input logic [31:0] a);
    issue(t, a, 32'h1234_5678);
    check({tag, ".err"},   64'(err),       64'd1);
    check({tag, ".valid"}, 64'(bus_valid), 64'd0);
    check({tag, ".rdy1"},  64'(req_ready), 64'd0);
    check({tag, ".done"},  64'(done),      64'd0);
    step();
    check({tag, ".err2"},  64'(err),       64'd0);
    check({tag, ".rdy2"},  64'(req_ready), 64'd1);
    check({tag, ".val2"},  64'(bus_valid), 64'd0);
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_type  = 2'b00;
    bus_ready = 1'b0;
    step();
    step();
    check("rst.rdy",   64'(req_ready), 64'd0);
    check("rst.valid", 64'(bus_valid), 64'd0);
    check("rst.done",  64'(done),      64'd0);
    check("rst.err",   64'(err),       64'd0);
    check("rst.addr",  64'(bus_addr),  64'd0);
    check("rst.data",  64'(bus_wdata), 64'd0);
    check("rst.be",    64'(bus_be),    64'd0);
    reset = 1'b1;
    step();
    check("rel.rdy", 64'(req_ready), 64'd1);

    // SW without backpressure
    bus_ready = 1'b1;
    issue(2'b10, 32'h0000_1004, 32'hDEAD_BEEF);
    chk_beat("sw.b0", 32'h1004, 16'hBEEF, 2'b11);
    step();
    chk_beat("sw.b1", 32'h1006, 16'hDEAD, 2'b11);
    step();
    chk_done("sw");
    step();
    check("sw.done_off", 64'(done), 64'd0);

    // SB upper and lower lanes
    issue(2'b00, 32'h0000_2003, 32'h0000_00A5);
    chk_beat("sbhi", 32'h2002, 16'hA5A5, 2'b10);
    step();
    chk_done("sbhi");
    step();
    issue(2'b00, 32'h0000_2002, 32'hFFFF_FF5A);
    chk_beat("sblo", 32'h2002, 16'h5A5A, 2'b01);
    step();
    chk_done("sblo");
    step();

    // Rejections
    reject("missh", 2'b01, 32'h0000_3001);
    reject("missw", 2'b10, 32'h0000_3002);
    reject("ill",   2'b11, 32'h0000_3000);

    // Backpressure: BEAT0 held for 4 cycles
    bus_ready = 1'b0;
    issue(2'b10, 32'h0000_4000, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      chk_beat("bp.b0", 32'h4000, 16'h5678, 2'b11);
      if (i == 3) bus_ready = 1'b1;
      step();
    end
    chk_beat("bp.b1", 32'h4002, 16'h1234, 2'b11);
    step();
    chk_done("bp");
    step();

    // Reset during BEAT1
    bus_ready = 1'b0;
    issue(2'b10, 32'h0000_5000, 32'hCAFE_F00D);
    chk_beat("mr.b0", 32'h5000, 16'hF00D, 2'b11);
    bus_ready = 1'b1;
    step();
    chk_beat("mr.b1", 32'h5002, 16'hCAFE, 2'b11);
    reset     = 1'b0;
    bus_ready = 1'b0;
    step();
    check("mr.valid", 64'(bus_valid), 64'd0);
    check("mr.done",  64'(done),      64'd0);
    check("mr.err",   64'(err),       64'd0);
    check("mr.rdy",   64'(req_ready), 64'd0);
    reset = 1'b1;
    step();
    check("mr.rdy2",  64'(req_ready), 64'd1);
    check("mr.done2", 64'(done),      64'd0);
    check("mr.val2",  64'(bus_valid), 64'd0);

    // Back-to-back SH with req_valid held
    bus_ready = 1'b1;
    req_valid = 1'b1;
    req_type  = 2'b01;
    req_addr  = 32'h0000_6000;
    req_wdata = 32'h0000_1111;
    step();
    chk_beat("bb.b0", 32'h6000, 16'h1111, 2'b11);
    req_addr  = 32'h0000_6002;
    req_wdata = 32'h0000_2222;
    step();
    chk_done("bb.d0");
    step();
    req_valid = 1'b0;
    chk_beat("bb.b1", 32'h6002, 16'h2222, 2'b11);
    step();
    chk_done("bb.d1");
    step();
    check("bb.idle_done", 64'(done),      64'd0);
    check("bb.idle_val",  64'(bus_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_narrower.md
# store_narrower

Serializes 32-bit CPU store requests (`sw`/`sh`/`sb`) onto a 16-bit peripheral write bus, which is the narrowing direction of the datapath's immediate/data widening. The block sits between the microsystem bridge and a 16-bit peripheral port.
- Word stores become two halfword beats.
- Halfword and byte stores become one beat with lane byte-enables.
- Misaligned or illegal requests are rejected with an `err` pulse so the CPU can raise AdES.

## Interface
- `ADDR_W`, 32, width of request and bus addresses.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-low reset.
- `req_valid` input 1: store request present.
- `req_ready` output 1: block idle and accepting; never depends on `req_valid`.
- `req_addr` input ADDR_W: byte address of the store.
- `req_wdata` input 32: store data; sb uses [7:0], sh uses [15:0].
- `req_type` input 2: 2'b00 SB, 2'b01 SH, 2'b10 SW, 2'b11 illegal.
- `bus_valid` output 1: beat present on the narrow bus.
- `bus_ready` input 1: peripheral accepts the beat.
- `bus_addr` output ADDR_W: halfword-aligned beat address, bit 0 always 0.
- `bus_wdata` output 16: beat data.
- `bus_be` output 2: byte enables, bit 0 selects [7:0] and bit 1 selects [15:8].
- `done` output 1: one-cycle pulse after the final beat handshake.
- `err` output 1: one-cycle pulse for a rejected request.

## Operation
- **States:**
  - `IDLE`: `req_ready`=1.
  - `BEAT0`, `BEAT1`: beat outstanding.
  - `ERR`: one cycle, pulses `err`.
- **Accept:** a request is accepted when `req_valid`&&`req_ready`. Addr, data and type are captured in that cycle.
- **Rejection:** `req_type`=11, SW with `addr[1:0]`≠0, or SH with `addr[0]`≠0 → `ERR`. No bus beat is issued. Next state is `IDLE`.
- **SW:**
  - `BEAT0`: addr `{addr[ADDR_W-1:2],2'b00}`, data `wdata[15:0]`, be 11.
  - `BEAT1`: addr +2, data `wdata[31:16]`, be 11.
- **SH:** `BEAT0` only. Addr `{addr[ADDR_W-1:1],1'b0}`, data `wdata[15:0]`, be 11.
- **SB:** `BEAT0` only. Addr `{addr[ADDR_W-1:1],1'b0}`, data `{wdata[7:0],wdata[7:0]}`, be = `addr[0]` ? 10 : 01.
- **Beat advance:** `BEAT0`→`BEAT1` (SW) or `BEAT0`→`IDLE` (SH/SB) on `bus_ready`. `BEAT1`→`IDLE` on `bus_ready`.
- **Completion:** `done` is registered. It is high in the cycle after the final handshake, which is the first cycle back in `IDLE`.
- **Bus ordering:** little-endian; the low halfword is always sent first.

## Timing
- **Reset values:** `bus_valid`=0, `done`=0, `err`=0, `bus_addr`/`bus_wdata`/`bus_be`=0, state `IDLE`.
- **During reset:** `req_ready`=0 while `reset` is low, and reset takes priority over every input. `req_ready`=1 from the first cycle after `reset` is released.
- **Latency:** accept at cycle T. `bus_valid` goes high at T+1. With `bus_ready` held at 1:
  - SW beats at T+1 and T+2, `done` at T+3.
  - SH/SB beat at T+1, `done` at T+2.
  - Rejected request: `err` at T+1, `req_ready` again at T+2.
- **Bus handshake:**
  - Once `bus_valid` is high, `bus_addr`/`bus_wdata`/`bus_be` stay stable until `bus_ready`.
  - `bus_valid` has no combinational path from `bus_ready`.
  - `bus_ready` while `bus_valid`=0 is ignored.
- **Back-to-back:** a new request may be accepted in the `done` cycle, so sustained SH throughput is one store per 2 cycles.
- **Backpressure:** `bus_ready` low for N cycles extends the current beat by N cycles. `req_ready` stays 0 throughout.
- **Reset mid-operation:** the beat is abandoned and `bus_valid`=0 the following cycle. No `done` or `err` is produced for that request.
- **Exclusivity:** `done` and `err` are never high together. Each is high for exactly one cycle per request.

## Structure
- **Shared package (`store_pkg`):**
  - store type codes SB/SH/SW/ILLEGAL;
  - FSM state encoding `IDLE`/`BEAT0`/`BEAT1`/`ERR`;
  - BE constants `BE_LO`=01, `BE_HI`=10, `BE_ALL`=11.
- **Sub-module `store_lane_mux`:** combinational. It takes the captured addr/data/type and the beat index, and produces `bus_addr`/`bus_wdata`/`bus_be`.
- **Top level:** holds the FSM, capture registers and the `done`/`err` registers.

## Test plan
- **SW, no backpressure:** SW addr 0x0000_1004, data 0xDEAD_BEEF, `bus_ready`=1.
  - Beats (0x1004, 0xBEEF, 11) then (0x1006, 0xDEAD, 11).
  - `done` at T+3.
- **SB upper lane:** SB addr 0x2003, data 0x0000_00A5 → one beat (0x2002, 0xA5A5, 10), `done` at T+2.
- **SB lower lane:** SB addr 0x2002 → be 01.
- **Misaligned SH:** SH addr 0x3001 → `err` at T+1, no `bus_valid`, `req_ready` at T+2.
- **Misaligned SW / illegal type:** SW addr 0x3002 → `err` at T+1; type 11 → `err` at T+1.
- **Backpressure:** SW with `bus_ready` low 3 cycles on `BEAT0`.
  - `bus_addr`/`bus_wdata` stable for 4 cycles, `req_ready`=0.
  - `done` 1 cycle after the `BEAT1` handshake.
- **Reset mid-operation:** reset low during `BEAT1` of an SW → `bus_valid`=0 next cycle, no `done`, `req_ready`=1 the cycle after release.
- **Back-to-back:** SH then SH with `req_valid` held → second accept in the first `done` cycle, 2-cycle spacing of `done` pulses.
